rx_frame_assembler: RTL and testbench
=====================================

Name: rx_frame_assembler

Overview:
- Consumes the bit-level event stream from sequence_decode (soc, eoc, data/data_valid, error) and assembles ISO/IEC 14443A PCD->PICC frames into bytes.
- Handles short frames (7 bits, no parity), standard frames (8 data bits plus an odd parity bit per byte) and trailing partial bytes (bit-oriented anticollision).
- Checks parity, enforces a maximum frame length and reports frame-level events to the protocol FSM downstream.
- Sits between sequence_decode and the ISO14443-3 framing/protocol layer.

Parameters:
- MAX_BYTES, 64: maximum number of complete bytes per frame. Must be ≥1. Counter width is $clog2(MAX_BYTES+1).

Ports:
- clk  input  1  system clock (13.56 MHz domain)
- rst  input  1  synchronous reset, active-high
- soc  input  1  start of comms, 1-tick pulse from sequence_decode
- eoc  input  1  end of comms, 1-tick pulse
- data  input  1  bit value, qualified by data_valid
- data_valid  input  1  1-tick pulse, one per received bit
- error  input  1  sequence error, 1-tick pulse
- out_soc  output  1  frame start pulse
- out_eoc  output  1  frame end pulse
- out_data  output  8  assembled byte, LSB = first received bit; unused MSBs = 0
- out_data_valid  output  1  1-tick pulse qualifying out_data/out_bits
- out_bits  output  3  valid bits in out_data; 0 means 8
- out_short_frame  output  1  high with out_eoc when the frame was a 7-bit short frame
- out_error  output  1  1-tick error pulse
- out_error_cause  output  2  0 = sequence, 1 = parity, 2 = overflow; qualified by out_error

Behaviour:
- Reset: all outputs 0, state IDLE, counters cleared. Reset asserted mid-frame aborts it silently, with no out_eoc.
- Latency: every output pulse is registered exactly 1 clk after the input pulse that causes it. At most one output pulse per cycle, except out_eoc with out_short_frame.
- States:
  - IDLE: soc -> out_soc, RX_DATA. bit_cnt = 0, byte_cnt = 0. All other inputs are ignored.
  - RX_DATA: each data_valid shifts data into shreg[bit_cnt] and increments bit_cnt. When bit_cnt reaches 8, go to RX_PARITY; bit_cnt = 0.
  - RX_PARITY: next data_valid is the parity bit. Odd parity must hold (popcount(byte) + parity odd).
    - Pass: out_data = byte, out_bits = 0, out_data_valid, byte_cnt++, back to RX_DATA.
    - Fail: out_error, cause = 1, go to ERROR. Byte is not emitted.
  - ERROR: ignore data_valid and error. eoc -> out_eoc, IDLE.
- Overflow: if a data_valid would start byte MAX_BYTES+1 (byte_cnt == MAX_BYTES in RX_DATA), emit out_error with cause = 2, go to ERROR.
- error input in RX_DATA/RX_PARITY: out_error, cause = 0, go to ERROR.
- eoc in RX_DATA:
  - byte_cnt == 0 and bit_cnt == 7: emit out_data (7 bits, MSB 0), out_bits = 7, out_data_valid. Next cycle emit out_eoc and out_short_frame.
  - bit_cnt in 1..7 after ≥1 byte: emit partial byte (out_bits = bit_cnt) as out_data_valid, then out_eoc next cycle.
  - bit_cnt == 0: out_eoc only.
  - byte_cnt == 0 and bit_cnt != 7, 0: out_error cause = 0, then out_eoc next cycle.
- eoc in RX_PARITY (byte without parity): out_error cause = 1, then out_eoc next cycle.
- Two-cycle eoc sequences: the second pulse is emitted from a one-cycle FLUSH state. Any input arriving in FLUSH is ignored; none is legal from sequence_decode.
- soc while not IDLE: restart the frame (out_soc, counters cleared) with no out_eoc for the aborted frame.
- Simultaneous input pulses (illegal upstream): priority is error > eoc > soc > data_valid.

Optional Feature:
- Macro RX_PARITY_CHECK_EN.
- Defined: parity checking as above.
- Not defined: the parity bit is consumed and discarded, cause 1 is never raised, and eoc in RX_PARITY produces out_eoc without error.

Test Plan:
- REQA short frame: soc, bits 0,1,1,0,0,1,0, eoc -> out_soc; out_data = 0x26, out_bits = 7; then out_eoc + out_short_frame.
- Standard 2 bytes: 0x93 (parity 1), 0x20 (parity 0), eoc -> out_data 0x93 then 0x20, both out_bits = 0; out_eoc; no error.
- Parity error: 0x93 with parity 0, more bits, eoc -> out_error cause 1; no byte emitted; later bits ignored; single out_eoc. With the macro undefined -> 0x93 emitted, no error.
- Anticollision partial: 0x93, 0x20 (valid parity), then 3 bits 1,0,1, eoc -> bytes 0x93, 0x20, then out_data = 0x05, out_bits = 3; out_eoc.
- Sequence error and restart: 4 bits, error pulse -> out_error cause 0; eoc -> out_eoc. Then soc mid-frame in a following frame -> out_soc, counters reset.
- Overflow (MAX_BYTES = 2): 3 valid bytes -> 2 bytes emitted, out_error cause 2 on first bit of byte 3; out_eoc on eoc. Reset mid-frame -> all outputs 0 next cycle.

Source files
------------

// File: rtl/rx_frame_assembler.sv
// ISO/IEC 14443A PCD->PICC frame assembler: bit events from sequence_decode to bytes/frame events.
// Define RX_PARITY_CHECK_EN to enable odd-parity checking; otherwise parity bits are discarded.
module rx_frame_assembler #(
    parameter int unsigned MAX_BYTES = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       soc,
    input  logic       eoc,
    input  logic       data,
    input  logic       data_valid,
    input  logic       error,
    output logic       out_soc,
    output logic       out_eoc,
    output logic [7:0] out_data,
    output logic       out_data_valid,
    output logic [2:0] out_bits,
    output logic       out_short_frame,
    output logic       out_error,
    output logic [1:0] out_error_cause
);

    localparam int unsigned BCW = $clog2(MAX_BYTES + 1);

    localparam logic [1:0] CAUSE_SEQ    = 2'd0;
    localparam logic [1:0] CAUSE_PARITY = 2'd1;
    localparam logic [1:0] CAUSE_OVF    = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RX_DATA,
        S_RX_PARITY,
        S_ERROR,
        S_FLUSH
    } state_e;

    state_e           state_q, state_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [BCW-1:0]   byte_cnt_q, byte_cnt_d;
    logic [7:0]       shreg_q, shreg_d;
    logic             short_q, short_d;

    logic             soc_q, soc_d;
    logic             eoc_q, eoc_d;
    logic [7:0]       data_q, data_d;
    logic             dv_q, dv_d;
    logic [2:0]       bits_q, bits_d;
    logic             sf_q, sf_d;
    logic             err_q, err_d;
    logic [1:0]       cause_q, cause_d;

    logic             par_ok;

`ifdef RX_PARITY_CHECK_EN
    assign par_ok = (^shreg_q) ^ data;
`else
    assign par_ok = 1'b1;
`endif

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        byte_cnt_d = byte_cnt_q;
        shreg_d    = shreg_q;
        short_d    = short_q;
        soc_d      = 1'b0;
        eoc_d      = 1'b0;
        data_d     = '0;
        dv_d       = 1'b0;
        bits_d     = '0;
        sf_d       = 1'b0;
        err_d      = 1'b0;
        cause_d    = '0;

        case (state_q)
            S_IDLE: begin
                if (soc) begin
                    soc_d      = 1'b1;
                    state_d    = S_RX_DATA;
                    bit_cnt_d  = '0;
                    byte_cnt_d = '0;
                end
            end

            S_RX_DATA, S_RX_PARITY: begin
                if (error) begin
                    err_d   = 1'b1;
                    cause_d = CAUSE_SEQ;
                    state_d = S_ERROR;
                end else if (eoc) begin
                    if (state_q == S_RX_PARITY) begin
`ifdef RX_PARITY_CHECK_EN
                        err_d   = 1'b1;
                        cause_d = CAUSE_PARITY;
                        short_d = 1'b0;
                        state_d = S_FLUSH;
`else
                        eoc_d   = 1'b1;
                        state_d = S_IDLE;
`endif
                    end else if (bit_cnt_q == 3'd0) begin
                        eoc_d   = 1'b1;
                        state_d = S_IDLE;
                    end else if (byte_cnt_q == '0 && bit_cnt_q != 3'd7) begin
                        err_d   = 1'b1;
                        cause_d = CAUSE_SEQ;
                        short_d = 1'b0;
                        state_d = S_FLUSH;
                    end else begin
                        // Short frame or trailing partial byte; bits above bit_cnt are already zero.
                        dv_d    = 1'b1;
                        data_d  = shreg_q;
                        bits_d  = bit_cnt_q;
                        short_d = (byte_cnt_q == '0);
                        state_d = S_FLUSH;
                    end
                end else if (soc) begin
                    soc_d      = 1'b1;
                    state_d    = S_RX_DATA;
                    bit_cnt_d  = '0;
                    byte_cnt_d = '0;
                end else if (data_valid) begin
                    if (state_q == S_RX_PARITY) begin
                        if (par_ok) begin
                            dv_d       = 1'b1;
                            data_d     = shreg_q;
                            byte_cnt_d = byte_cnt_q + 1'b1;
                            state_d    = S_RX_DATA;
                        end else begin
                            err_d   = 1'b1;
                            cause_d = CAUSE_PARITY;
                            state_d = S_ERROR;
                        end
                    end else if (byte_cnt_q == BCW'(MAX_BYTES)) begin
                        err_d   = 1'b1;
                        cause_d = CAUSE_OVF;
                        state_d = S_ERROR;
                    end else begin
                        if (bit_cnt_q == 3'd0) begin
                            shreg_d = {7'b0, data};
                        end else begin
                            shreg_d[bit_cnt_q] = data;
                        end
                        if (bit_cnt_q == 3'd7) begin
                            bit_cnt_d = '0;
                            state_d   = S_RX_PARITY;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 3'd1;
                        end
                    end
                end
            end

            S_ERROR: begin
                if (eoc) begin
                    eoc_d   = 1'b1;
                    state_d = S_IDLE;
                end else if (soc) begin
                    soc_d      = 1'b1;
                    state_d    = S_RX_DATA;
                    bit_cnt_d  = '0;
                    byte_cnt_d = '0;
                end
            end

            S_FLUSH: begin
                eoc_d   = 1'b1;
                sf_d    = short_q;
                state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            bit_cnt_q  <= '0;
            byte_cnt_q <= '0;
            shreg_q    <= '0;
            short_q    <= 1'b0;
            soc_q      <= 1'b0;
            eoc_q      <= 1'b0;
            data_q     <= '0;
            dv_q       <= 1'b0;
            bits_q     <= '0;
            sf_q       <= 1'b0;
            err_q      <= 1'b0;
            cause_q    <= '0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            shreg_q    <= shreg_d;
            short_q    <= short_d;
            soc_q      <= soc_d;
            eoc_q      <= eoc_d;
            data_q     <= data_d;
            dv_q       <= dv_d;
            bits_q     <= bits_d;
            sf_q       <= sf_d;
            err_q      <= err_d;
            cause_q    <= cause_d;
        end
    end

    assign out_soc         = soc_q;
    assign out_eoc         = eoc_q;
    assign out_data        = data_q;
    assign out_data_valid  = dv_q;
    assign out_bits        = bits_q;
    assign out_short_frame = sf_q;
    assign out_error       = err_q;
    assign out_error_cause = cause_q;

endmodule

// File: tb/tb_rx_frame_assembler.sv
// Self-checking bench for rx_frame_assembler: directed and random frames vs. a frame-level event model.
module tb_rx_frame_assembler;

    localparam int MAXB = 2;
    localparam int INF  = 32'h7fffffff;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       soc = 1'b0, eoc = 1'b0, data = 1'b0, data_valid = 1'b0, error = 1'b0;
    logic       out_soc, out_eoc, out_data_valid, out_short_frame, out_error;
    logic [7:0] out_data;
    logic [2:0] out_bits;
    logic [1:0] out_error_cause;

    rx_frame_assembler #(.MAX_BYTES(MAXB)) dut (
        .clk(clk), .rst(rst), .soc(soc), .eoc(eoc), .data(data),
        .data_valid(data_valid), .error(error),
        .out_soc(out_soc), .out_eoc(out_eoc), .out_data(out_data),
        .out_data_valid(out_data_valid), .out_bits(out_bits),
        .out_short_frame(out_short_frame), .out_error(out_error),
        .out_error_cause(out_error_cause)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;
    int stamp;
    logic [49:0] obs_q[$];
    logic [49:0] exp_q[$];
    logic [7:0]  fb[0:3];

    // Event word: {cycle, soc, eoc, short, data_valid, error, data, bits, cause}
    function automatic logic [49:0] ev(input int c, input logic so, input logic eo, input logic sf,
                                       input logic dv, input logic er, input logic [7:0] d,
                                       input logic [2:0] b, input logic [1:0] ca);
        return {32'(c), so, eo, sf, dv, er, d, b, ca};
    endfunction

    always @(negedge clk) begin
        if (out_soc | out_eoc | out_data_valid | out_error | out_short_frame)
            obs_q.push_back(ev(cyc, out_soc, out_eoc, out_short_frame, out_data_valid, out_error,
                               out_data_valid ? out_data : 8'h00,
                               out_data_valid ? out_bits : 3'd0,
                               out_error ? out_error_cause : 2'd0));
    end

    task automatic tick(input logic s, input logic e, input logic dv, input logic d, input logic er);
        @(negedge clk);
        soc = s; eoc = e; data_valid = dv; data = d; error = er;
        stamp = cyc;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(0, 0, 0, 0, 0);
    endtask

    task automatic check_events(input string tag);
        int n;
        #1;
        n_cmp++;
        assert (obs_q.size() === exp_q.size()) else begin
            n_bad++;
            $error("FAIL %s event_count observed=%0d expected=%0d", tag, obs_q.size(), exp_q.size());
        end
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            n_cmp++;
            assert (obs_q[i] === exp_q[i]) else begin
                n_bad++;
                $error("FAIL %s ev%0d observed=%h expected=%h", tag, i, obs_q[i], exp_q[i]);
            end
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic check_quiet(input string tag);
        logic [18:0] o;
        #1;
        o = {out_soc, out_eoc, out_data, out_data_valid, out_bits, out_short_frame, out_error, out_error_cause};
        n_cmp++;
        assert (o === 19'd0) else begin
            n_bad++;
            $error("FAIL %s outputs observed=%h expected=0", tag, o);
        end
    endtask

    // Drives one frame (bytes from fb[], optional bad parity, trailing bits, error pulse,
    // abort-by-next-soc) and appends the expected output events computed from frame rules.
    task automatic run_frame(input int nbytes, input int trail, input logic [7:0] tval,
                             input int bad_par, input int err_at, input bit abort);
        logic bits[$];
        int   bc[$];
        int   L, soc_c, err_c, eoc_c, fail_c, full, rem, g;
        logic [1:0] cause;
        logic [7:0] pv;

        for (int k = 0; k < nbytes; k++) begin
            for (int j = 0; j < 8; j++) bits.push_back(fb[k][j]);
            bits.push_back((~^fb[k]) ^ (k == bad_par));
        end
        for (int j = 0; j < trail; j++) bits.push_back(tval[j]);
        L = bits.size();

        err_c = INF;
        eoc_c = 0;
        tick(1, 0, 0, 0, 0);
        soc_c = stamp;
        for (int i = 0; i < L; i++) begin
            if (i == err_at) begin
                tick(0, 0, 0, 0, 1);
                err_c = stamp;
            end
            g = $urandom_range(0, 2);
            idle(g);
            tick(0, 0, 1, bits[i], 0);
            bc.push_back(stamp);
        end
        if (err_at == L) begin
            tick(0, 0, 0, 0, 1);
            err_c = stamp;
        end
        if (!abort) begin
            g = $urandom_range(0, 2);
            idle(g);
            tick(0, 1, 0, 0, 0);
            eoc_c = stamp;
            idle(3);
        end

        exp_q.push_back(ev(soc_c + 1, 1, 0, 0, 0, 0, 8'h00, 3'd0, 2'd0));
        fail_c = INF;
        cause  = 2'd0;
        if (err_at >= 0) fail_c = err_c;
        if (L > 9 * MAXB && bc[9 * MAXB] < fail_c) begin
            fail_c = bc[9 * MAXB];
            cause  = 2'd2;
        end
`ifdef RX_PARITY_CHECK_EN
        if (bad_par >= 0 && bad_par < nbytes && bc[9 * bad_par + 8] < fail_c) begin
            fail_c = bc[9 * bad_par + 8];
            cause  = 2'd1;
        end
`endif
        for (int k = 0; k < nbytes; k++)
            if (bc[9 * k + 8] < fail_c)
                exp_q.push_back(ev(bc[9 * k + 8] + 1, 0, 0, 0, 1, 0, fb[k], 3'd0, 2'd0));

        if (fail_c != INF) begin
            exp_q.push_back(ev(fail_c + 1, 0, 0, 0, 0, 1, 8'h00, 3'd0, cause));
            if (!abort) exp_q.push_back(ev(eoc_c + 1, 0, 1, 0, 0, 0, 8'h00, 3'd0, 2'd0));
        end else if (!abort) begin
            full = L / 9;
            rem  = L % 9;
            if (rem == 8) begin
`ifdef RX_PARITY_CHECK_EN
                exp_q.push_back(ev(eoc_c + 1, 0, 0, 0, 0, 1, 8'h00, 3'd0, 2'd1));
                exp_q.push_back(ev(eoc_c + 2, 0, 1, 0, 0, 0, 8'h00, 3'd0, 2'd0));
`else
                exp_q.push_back(ev(eoc_c + 1, 0, 1, 0, 0, 0, 8'h00, 3'd0, 2'd0));
`endif
            end else if (rem == 0) begin
                exp_q.push_back(ev(eoc_c + 1, 0, 1, 0, 0, 0, 8'h00, 3'd0, 2'd0));
            end else if (full == 0 && rem < 7) begin
                exp_q.push_back(ev(eoc_c + 1, 0, 0, 0, 0, 1, 8'h00, 3'd0, 2'd0));
                exp_q.push_back(ev(eoc_c + 2, 0, 1, 0, 0, 0, 8'h00, 3'd0, 2'd0));
            end else begin
                pv = 8'h00;
                for (int j = 0; j < rem; j++) pv[j] = bits[9 * full + j];
                exp_q.push_back(ev(eoc_c + 1, 0, 0, 0, 1, 0, pv, 3'(rem), 2'd0));
                exp_q.push_back(ev(eoc_c + 2, 0, 1, full == 0, 0, 0, 8'h00, 3'd0, 2'd0));
            end
        end
    endtask

    initial begin
        int nb, tr, bp, ea, ab, L;

        idle(3);
        check_quiet("reset_state");
        rst = 1'b0;
        idle(2);

        // REQA short frame: 0x26 as 7 bits
        run_frame(0, 7, 8'h26, -1, -1, 0);
        check_events("reqa_short");

        fb[0] = 8'h93; fb[1] = 8'h20;
        run_frame(2, 0, 8'h00, -1, -1, 0);
        check_events("two_bytes");

        run_frame(1, 4, 8'h0b, 0, -1, 0);
        check_events("parity_error");

        run_frame(2, 3, 8'h05, -1, -1, 0);
        check_events("anticoll_partial");

        run_frame(0, 4, 8'h0a, -1, 4, 0);
        check_events("seq_error");

        run_frame(1, 2, 8'h03, -1, -1, 1);
        run_frame(1, 0, 8'h00, -1, -1, 0);
        check_events("soc_restart");

        fb[2] = 8'h5a;
        run_frame(3, 0, 8'h00, -1, -1, 0);
        check_events("overflow");

        run_frame(0, 0, 8'h00, -1, -1, 0);
        check_events("empty_frame");

        run_frame(1, 8, 8'hc3, -1, -1, 0);
        check_events("eoc_in_parity");

        // Reset right after a byte is emitted: aborted frame, then quiet outputs
        fb[0] = 8'h3c;
        run_frame(1, 0, 8'h00, -1, -1, 1);
        tick(0, 0, 0, 0, 0);
        rst = 1'b1;
        tick(0, 0, 0, 0, 0);
        check_quiet("reset_midframe");
        rst = 1'b0;
        idle(3);
        check_events("reset_midframe_events");

        for (int f = 0; f < 60; f++) begin
            for (int k = 0; k < 4; k++) fb[k] = 8'($urandom);
            nb = $urandom_range(0, 3);
            tr = $urandom_range(0, 7);
            bp = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : -1;
            L  = 9 * nb + tr;
            ea = ($urandom_range(0, 4) == 0) ? $urandom_range(0, L) : -1;
            ab = ($urandom_range(0, 7) == 0) ? 1 : 0;
            run_frame(nb, tr, 8'($urandom), bp, ea, ab[0]);
            if (ab == 0) check_events("random_frame");
        end
        run_frame(0, 0, 8'h00, -1, -1, 0);
        check_events("final_frame");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
